// File: rtl/instr_fetch_queue_if.sv
// Fetch-to-decode queue bundle: upstream PC/instruction pair, redirect and decode handshake.
// master = fetch/decode side driving the queue, slave = the queue itself.
interface instr_fetch_queue_if #(
    parameter int CW = 3
);
    logic [31:0]   PCResult;
    logic [31:0]   Instruction;
    logic          InValid;
    logic          PCWrite;
    logic          Flush;
    logic          DecodeReady;
    logic          OutValid;
    logic [31:0]   OutInstruction;
    logic [31:0]   OutPC;
    logic [CW-1:0] Count;

    modport master (
        output PCResult, Instruction, InValid, Flush, DecodeReady,
        input  PCWrite, OutValid, OutInstruction, OutPC, Count
    );

    modport slave (
        input  PCResult, Instruction, InValid, Flush, DecodeReady,
        output PCWrite, OutValid, OutInstruction, OutPC, Count
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// Circular FIFO of {PC, instruction} pairs between fetch and decode, with flush and PC stall.
// Define FETCH_QUEUE_BYPASS_EN to let an empty queue forward the incoming pair in the same cycle.
module instr_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic               Clk_i,
    input  logic               Reset_i,
    instr_fetch_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);

    logic [31:0]   pcMem_q    [DEPTH];
    logic [31:0]   instrMem_q [DEPTH];
    logic [PW-1:0] wrPtr_q, wrPtr_d;
    logic [PW-1:0] rdPtr_q, rdPtr_d;
    logic [CW-1:0] count_q, count_d;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic storedValid;
    logic bypassTake;

    assign full        = (count_q == CW'(DEPTH));
    assign empty       = (count_q == '0);
    assign storedValid = ~empty & ~bus.Flush;

    // Head outputs are forced to zero whenever nothing valid is presented.
`ifdef FETCH_QUEUE_BYPASS_EN
    logic bypass;
    assign bypass              = empty & bus.InValid & ~bus.Flush;
    assign bypassTake          = bypass & bus.DecodeReady;
    assign bus.OutValid        = storedValid | bypass;
    assign bus.OutPC           = storedValid ? pcMem_q[rdPtr_q]
                               : (bypass ? bus.PCResult : 32'h0);
    assign bus.OutInstruction  = storedValid ? instrMem_q[rdPtr_q]
                               : (bypass ? bus.Instruction : 32'h0);
`else
    assign bypassTake          = 1'b0;
    assign bus.OutValid        = storedValid;
    assign bus.OutPC           = storedValid ? pcMem_q[rdPtr_q] : 32'h0;
    assign bus.OutInstruction  = storedValid ? instrMem_q[rdPtr_q] : 32'h0;
`endif

    assign push        = bus.InValid & ~full & ~bus.Flush & ~bypassTake;
    assign pop         = storedValid & bus.DecodeReady;
    assign bus.PCWrite = ~full | bus.Flush;
    assign bus.Count   = count_q;

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (bus.Flush) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (push) wrPtr_d = wrPtr_q + PW'(1);
            if (pop)  rdPtr_d = rdPtr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge Clk_i or negedge Reset_i) begin
        if (!Reset_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge Clk_i or negedge Reset_i) begin
        if (!Reset_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                pcMem_q[i]    <= 32'h0;
                instrMem_q[i] <= 32'h0;
            end
        end else if (push) begin
            pcMem_q[wrPtr_q]    <= bus.PCResult;
            instrMem_q[wrPtr_q] <= bus.Instruction;
        end
    end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Scoreboard bench for instr_fetch_queue: stimulus predicts each cycle's outputs from a queue model,
// a separate monitor compares them just before the next rising edge.
module tb_instr_fetch_queue;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        pcWrite;
        logic [31:0] count;
    } resp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    instr_fetch_queue_if #(.CW(CW)) bus ();

    instr_fetch_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
        .Clk_i   (clk),
        .Reset_i (rst_n),
        .bus     (bus)
    );

    entry_t model[$];
    resp_t  expResp[$];
    int     errors = 0;
    int     checks = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs and predict what the queue must present during that cycle.
    task automatic applyStimulus(input logic inValid, input logic [31:0] pc, input logic [31:0] instr,
                                 input logic flush, input logic decodeReady);
        resp_t  r;
        entry_t e;
        int     sz;
        bit     consumed;
        @(negedge clk);
        bus.InValid     = inValid;
        bus.PCResult    = pc;
        bus.Instruction = instr;
        bus.Flush       = flush;
        bus.DecodeReady = decodeReady;
        sz        = model.size();
        r.count   = 32'(sz);
        r.pcWrite = (sz < DEPTH) || flush;
        r.valid   = 1'b0;
        r.pc      = 32'h0;
        r.instr   = 32'h0;
        if (!flush && sz > 0) begin
            r.valid = 1'b1;
            r.pc    = model[0].pc;
            r.instr = model[0].instr;
        end else if (!flush && BYPASS && inValid) begin
            r.valid = 1'b1;
            r.pc    = pc;
            r.instr = instr;
        end
        expResp.push_back(r);
        if (flush) begin
            model.delete();
        end else begin
            consumed = r.valid && decodeReady;
            if (consumed && sz > 0) void'(model.pop_front());
            if (inValid && sz < DEPTH && !(consumed && sz == 0)) begin
                e.pc    = pc;
                e.instr = instr;
                model.push_back(e);
            end
        end
    endtask

    task automatic idleCycle(input logic decodeReady);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, decodeReady);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, " Count"},          32'(bus.Count),    32'h0);
        checkOutput({tag, " OutValid"},       32'(bus.OutValid), 32'h0);
        checkOutput({tag, " OutPC"},          bus.OutPC,         32'h0);
        checkOutput({tag, " OutInstruction"}, bus.OutInstruction, 32'h0);
        checkOutput({tag, " PCWrite"},        32'(bus.PCWrite),  32'h1);
    endtask

    initial begin : monitor
        resp_t r;
        forever begin
            @(negedge clk);
            #4;
            if (expResp.size() > 0) begin
                r = expResp.pop_front();
                checkOutput("OutValid",       32'(bus.OutValid), 32'(r.valid));
                checkOutput("Count",          32'(bus.Count),    r.count);
                checkOutput("PCWrite",        32'(bus.PCWrite),  32'(r.pcWrite));
                checkOutput("OutPC",          bus.OutPC,         r.pc);
                checkOutput("OutInstruction", bus.OutInstruction, r.instr);
            end
        end
    end

    initial begin : stimulus
        bus.InValid     = 1'b0;
        bus.PCResult    = 32'h0;
        bus.Instruction = 32'h0;
        bus.Flush       = 1'b0;
        bus.DecodeReady = 1'b0;
        #2;
        checkResetState("power-on reset");
        #1 rst_n = 1'b1;

        // Fill to capacity; the fifth pair must be refused while the PC is held.
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, 32'(4 * i), 32'(8'h11 * (i + 1)), 1'b0, 1'b0);
        applyStimulus(1'b1, 32'd16, 32'h55, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'd16, 32'h55, 1'b0, 1'b0);

        // Drain in order, then observe the empty queue.
        for (int i = 0; i < 4; i++) idleCycle(1'b1);
        idleCycle(1'b1);

        // Two entries, then simultaneous push/pop across pointer wrap.
        applyStimulus(1'b1, 32'd100, 32'hA0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'd104, 32'hA1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++)
            applyStimulus(1'b1, 32'(108 + 4 * i), 32'(32'hA2 + i), 1'b0, 1'b1);

        // Third entry, then flush with a competing input.
        applyStimulus(1'b1, 32'd200, 32'hB0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'd2020, 32'hC0, 1'b1, 1'b1);
        idleCycle(1'b0);
        idleCycle(1'b1);

        // Async reset mid-cycle with three queued entries.
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 32'(300 + 4 * i), 32'(32'hD0 + i), 1'b0, 1'b0);
        @(negedge clk);
        bus.InValid     = 1'b0;
        bus.DecodeReady = 1'b0;
        #2 rst_n = 1'b0;
        #1 checkResetState("async reset");
        model.delete();
        @(negedge clk);
        rst_n = 1'b1;

        // Empty queue presented with a pair and a ready decoder.
        applyStimulus(1'b1, 32'd2021, 32'hE0, 1'b0, 1'b1);
        idleCycle(1'b1);
        idleCycle(1'b1);

        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(99, 0) < 70,
                          {$urandom_range(32'hFFFF, 0), 2'b00},
                          $urandom,
                          $urandom_range(99, 0) < 5,
                          $urandom_range(99, 0) < 50);
        end
        for (int i = 0; i < DEPTH + 1; i++) idleCycle(1'b1);

        @(negedge clk);
        #6;
        checks++;
        if (expResp.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard drain: got %0d pending, expected 0", expResp.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4: number of queue entries; power of two, 2..16.
REQ-002 Parameter CW, default 3: Count width, equal to clog2(DEPTH+1).
REQ-003 Clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Reset  input  1  reset, asynchronous and active-low.
REQ-005 PCResult  input  32  address of the instruction being fetched, from the program counter.
REQ-006 Instruction  input  32  instruction word read from instruction memory at PCResult.
REQ-007 InValid  input  1  PCResult/Instruction pair is valid this cycle.
REQ-008 PCWrite  output  1  1 = program counter may advance this cycle; 0 = hold the PC.
REQ-009 Flush  input  1  branch/jump redirect; discard all queued and incoming entries.
REQ-010 DecodeReady  input  1  decode stage accepts the head entry this cycle.
REQ-011 OutValid  output  1  head entry is valid.
REQ-012 OutInstruction  output  32  head entry instruction word.
REQ-013 OutPC  output  32  head entry address.
REQ-014 Count  output  CW  number of occupied entries.

Function
REQ-015 The block SHALL be a circular FIFO of DEPTH {PC, instruction} entries, with write and read pointers wrapping modulo DEPTH.
REQ-016 Full SHALL be Count==DEPTH, and Empty SHALL be Count==0.
REQ-017 push SHALL equal InValid & ~Full & ~Flush, and pop SHALL equal OutValid & DecodeReady.
REQ-018 On push, the input pair SHALL be written at the write pointer, and the write pointer SHALL increment at the edge.
REQ-019 On pop, the read pointer SHALL increment at the edge.
REQ-020 Count SHALL be updated by +1 on push only, -1 on pop only, and unchanged on both or neither.
REQ-021 The following conditions SHALL hold:
  - OutValid = ~Empty & ~Flush.
  - OutInstruction/OutPC reflect the entry at the read pointer combinationally.
REQ-022 PCWrite SHALL equal ~Full | Flush, combinational from current state and Flush only.
REQ-023 When Full, push and pop in the same cycle SHALL result in the pop only; the input is not accepted and PCWrite=0 in that cycle.
REQ-024 When Empty and without bypass, InValid SHALL produce OutValid=1 no earlier than the next cycle, giving a minimum latency of 1 cycle.
REQ-025 On Flush=1 at an edge, both pointers and Count SHALL go to 0, and neither a push nor a pop SHALL occur in that cycle.
REQ-026 Flush SHALL take priority over InValid and DecodeReady.
REQ-027 InValid=1 while PCWrite=0 SHALL be ignored with no state change; the upstream stage re-presents the same pair because the PC is held.
REQ-028 Entry storage contents SHALL never reach the outputs while OutValid=0, except as the reset values below.

Reset
REQ-029 While Reset=0, the following SHALL be cleared immediately, independent of Clk:
  - pointers = 0, Count = 0, OutValid = 0;
  - all storage = 32'h0, so OutInstruction = 0 and OutPC = 0;
  - PCWrite = 1.
REQ-030 Reset asserted mid-operation SHALL discard all queued entries.
REQ-031 The first push SHALL be possible at the first rising edge after Reset returns to 1.

Configuration
REQ-032 Macro FETCH_QUEUE_BYPASS_EN SHALL control same-cycle bypass.
REQ-033 With FETCH_QUEUE_BYPASS_EN defined, when Empty & InValid & ~Flush, the block SHALL behave as follows:
  - OutValid = 1, with OutInstruction/OutPC driven directly from the inputs the same cycle.
  - If DecodeReady=1, the pair is consumed without being written, and Count stays 0.
  - Otherwise, the pair is pushed normally.
REQ-034 Without FETCH_QUEUE_BYPASS_EN, the block SHALL have no input-to-output combinational path and a 1-cycle minimum latency.

Verification
REQ-035 Fill: DecodeReady=0; push PCs 0, 4, 8, 12 with instructions 0x11..0x44 -> Count=4, PCWrite=0, and a fifth pair (PC 16) is not accepted.
REQ-036 Drain order: from full, DecodeReady=1 for 4 cycles -> OutPC sequence 0, 4, 8, 12, then OutValid=0 and Count=0.
REQ-037 Wrap and simultaneous: push and pop every cycle for 10 cycles starting at Count=2 -> Count stays 2, and OutPC increments by 4 in order across pointer wrap.
REQ-038 Flush: with Count=3, assert Flush with InValid=1 (PC 2020) -> the next cycle has Count=0 and OutValid=0, and PC 2020 is not stored.
REQ-039 Async reset: with Count=3, drop Reset mid-cycle -> Count=0, OutValid=0, OutPC=0, and PCWrite=1 before the next edge.
REQ-040 Bypass: with Empty, FETCH_QUEUE_BYPASS_EN defined, InValid=1 (PC 2021) and DecodeReady=1 -> OutValid=1 and OutPC=2021 the same cycle, with Count=0 afterward; without the macro, OutValid=1 only one cycle later.
